// File: rtl/reg_file_en.sv
// Register bank of DEPTH x WIDTH entries with one lane-masked write port and
// two combinational read ports, with optional write-to-read bypass and optional hardwired-zero entry 0.
module reg_file_en #(
  parameter int WIDTH    = 7,
  parameter int DEPTH    = 8,
  parameter int NLANES   = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [AW-1:0]     waddr,
  input  logic [NLANES-1:0] be,
  input  logic [WIDTH-1:0]  d,
  input  logic [AW-1:0]     raddr_a,
  output logic [WIDTH-1:0]  q_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [WIDTH-1:0]  q_b
);

  localparam int LW = WIDTH / NLANES;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0] wr_sel_s;
  logic [WIDTH-1:0] wr_old_s;
  logic [WIDTH-1:0] wr_new_s;
  logic [WIDTH-1:0] rd_word_s [DEPTH];
  logic [WIDTH-1:0] q_a_s;
  logic [WIDTH-1:0] q_b_s;

  function automatic logic [WIDTH-1:0] lane_merge(
    input logic [WIDTH-1:0]  old_word,
    input logic [WIDTH-1:0]  new_word,
    input logic [NLANES-1:0] mask
  );
    logic [WIDTH-1:0] merged;
    merged = old_word;
    for (int i = 0; i < NLANES; i++) begin
      if (mask[i]) begin
        merged[i*LW +: LW] = new_word[i*LW +: LW];
      end else begin
        merged[i*LW +: LW] = old_word[i*LW +: LW];
      end
    end
    return merged;
  endfunction

  // Per-entry write decode; an out-of-range waddr matches no entry.
  always_comb begin
    wr_sel_s = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((ZERO_REG != 0) && (k == 0)) begin
        wr_sel_s[k] = 1'b0;
      end else begin
        wr_sel_s[k] = en && !reset && (waddr == AW'(k));
      end
    end
  end

  // Stored word at the write address, merged with the lane-masked write data.
  always_comb begin
    wr_old_s = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (waddr == AW'(k)) begin
        wr_old_s = mem_r[k];
      end else begin
        wr_old_s = wr_old_s;
      end
    end
    wr_new_s = lane_merge(wr_old_s, d, be);
  end

  // Storage: reset clears everything and wins over any write in that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (wr_sel_s[k]) begin
          mem_r[k] <= wr_new_s;
        end
      end
    end
  end

  // Visible value of each entry, including the same-cycle bypass.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      if ((ZERO_REG != 0) && (k == 0)) begin
        rd_word_s[k] = '0;
      end else if ((BYPASS != 0) && wr_sel_s[k]) begin
        rd_word_s[k] = wr_new_s;
      end else begin
        rd_word_s[k] = mem_r[k];
      end
    end
  end

  // Read multiplexers; addresses beyond DEPTH fall through to zero.
  always_comb begin
    q_a_s = '0;
    q_b_s = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (raddr_a == AW'(k)) begin
        q_a_s = rd_word_s[k];
      end else begin
        q_a_s = q_a_s;
      end
      if (raddr_b == AW'(k)) begin
        q_b_s = rd_word_s[k];
      end else begin
        q_b_s = q_b_s;
      end
    end
  end

  assign q_a = q_a_s;
  assign q_b = q_b_s;

  reg_file_en_chk #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_chk (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .raddr_a(raddr_a),
    .raddr_b(raddr_b),
    .q_a    (q_a),
    .q_b    (q_b)
  );

endmodule

// Structural properties of the read ports, kept apart from the datapath.
module reg_file_en_chk #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input logic             clk,
  input logic             reset,
  input logic             en,
  input logic [AW-1:0]    raddr_a,
  input logic [AW-1:0]    raddr_b,
  input logic [WIDTH-1:0] q_a,
  input logic [WIDTH-1:0] q_b
);

  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

  a_same_addr: assert property (@(posedge clk) (raddr_a == raddr_b) |-> (q_a == q_b));
  a_oob_a: assert property (@(posedge clk) ({1'b0, raddr_a} >= DEPTH_W) |-> (q_a == '0));
  a_oob_b: assert property (@(posedge clk) ({1'b0, raddr_b} >= DEPTH_W) |-> (q_b == '0));
  a_post_reset: assert property (@(posedge clk) ($past(reset) && !en) |-> ((q_a == '0) && (q_b == '0)));

endmodule

// File: tb/tb_reg_file_en.sv
// Directed bench for reg_file_en: four instances cover the default, no-bypass,
// short/zero-entry and two-lane configurations.
module tb_reg_file_en;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [2:0] waddr;
  logic [2:0] raddr_a;
  logic [2:0] raddr_b;
  logic [0:0] be1;
  logic [6:0] d7;
  logic [1:0] be2;
  logic [7:0] d8;
  logic [6:0] qa_byp, qb_byp, qa_nob, qb_nob, qa_bnd, qb_bnd;
  logic [7:0] qa_ln, qb_ln;

  int passes = 0;
  int fails  = 0;
  int checks = 0;

  always #50 clk = ~clk;

  reg_file_en #(.WIDTH(7), .DEPTH(8), .NLANES(1), .BYPASS(1), .ZERO_REG(0)) dut_byp (
    .clk(clk), .reset(reset), .en(en), .waddr(waddr), .be(be1), .d(d7),
    .raddr_a(raddr_a), .q_a(qa_byp), .raddr_b(raddr_b), .q_b(qb_byp)
  );

  reg_file_en #(.WIDTH(7), .DEPTH(8), .NLANES(1), .BYPASS(0), .ZERO_REG(0)) dut_nob (
    .clk(clk), .reset(reset), .en(en), .waddr(waddr), .be(be1), .d(d7),
    .raddr_a(raddr_a), .q_a(qa_nob), .raddr_b(raddr_b), .q_b(qb_nob)
  );

  reg_file_en #(.WIDTH(7), .DEPTH(6), .NLANES(1), .BYPASS(1), .ZERO_REG(1)) dut_bnd (
    .clk(clk), .reset(reset), .en(en), .waddr(waddr), .be(be1), .d(d7),
    .raddr_a(raddr_a), .q_a(qa_bnd), .raddr_b(raddr_b), .q_b(qb_bnd)
  );

  reg_file_en #(.WIDTH(8), .DEPTH(8), .NLANES(2), .BYPASS(1), .ZERO_REG(0)) dut_ln (
    .clk(clk), .reset(reset), .en(en), .waddr(waddr), .be(be2), .d(d8),
    .raddr_a(raddr_a), .q_a(qa_ln), .raddr_b(raddr_b), .q_b(qb_ln)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [2:0] a, input logic [2:0] b);
    raddr_a = a;
    raddr_b = b;
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; en = 1'b0; waddr = 3'd0; raddr_a = 3'd0; raddr_b = 3'd0;
    be1 = 1'b1; d7 = 7'h00; be2 = 2'b00; d8 = 8'h00;
    tick();
    reset = 1'b0;

    // Reset state
    look(3'd3, 3'd7);
    chk("rst_byp_a3", {1'b0, qa_byp}, 8'h00);
    chk("rst_nob_b7", {1'b0, qb_nob}, 8'h00);
    look(3'd0, 3'd2);
    chk("rst_bnd_a0", {1'b0, qa_bnd}, 8'h00);
    chk("rst_ln_b2", qb_ln, 8'h00);

    // Preload 1..7 with 55, then reset with a competing write to 3
    en = 1'b1; be1 = 1'b1; be2 = 2'b00; d7 = 7'h55;
    for (int w = 1; w < 8; w++) begin
      waddr = 3'(w);
      tick();
    end
    en = 1'b0;
    look(3'd7, 3'd1);
    chk("pre_byp_a7", {1'b0, qa_byp}, 8'h55);
    chk("pre_bnd_a7_oob", {1'b0, qa_bnd}, 8'h00);
    chk("pre_bnd_b1", {1'b0, qb_bnd}, 8'h55);
    reset = 1'b1; en = 1'b1; waddr = 3'd3; d7 = 7'h7F;
    look(3'd3, 3'd3);
    chk("rstcyc_byp_a3_nobypass", {1'b0, qa_byp}, 8'h55);
    chk("rstcyc_nob_b3", {1'b0, qb_nob}, 8'h55);
    tick();
    reset = 1'b0; en = 1'b0;
    for (int a = 0; a < 8; a++) begin
      look(3'(a), 3'(7 - a));
      chk($sformatf("postrst_byp_a%0d", a), {1'b0, qa_byp}, 8'h00);
    end
    look(3'd3, 3'd3);
    chk("postrst_nob_b3", {1'b0, qb_nob}, 8'h00);

    // Basic write / read
    en = 1'b1; waddr = 3'd5; d7 = 7'b0000111; be1 = 1'b1;
    look(3'd5, 3'd5);
    chk("wr5_byp_a_bypass", {1'b0, qa_byp}, 8'h07);
    chk("wr5_nob_a_old", {1'b0, qa_nob}, 8'h00);
    tick();
    en = 1'b0; d7 = 7'h7F;
    look(3'd5, 3'd5);
    chk("wr5_byp_a", {1'b0, qa_byp}, 8'h07);
    chk("wr5_nob_b", {1'b0, qb_nob}, 8'h07);
    chk("wr5_bnd_a", {1'b0, qa_bnd}, 8'h07);
    tick();
    look(3'd5, 3'd5);
    chk("en0_byp_a5_kept", {1'b0, qa_byp}, 8'h07);

    // Lane mask on the 8-bit two-lane instance; be=0 on the others
    en = 1'b1; waddr = 3'd2; be1 = 1'b0; d7 = 7'h7F; be2 = 2'b11; d8 = 8'hA5;
    tick();
    en = 1'b0;
    look(3'd2, 3'd2);
    chk("ln_full_a2", qa_ln, 8'hA5);
    chk("be0_byp_a2", {1'b0, qa_byp}, 8'h00);
    en = 1'b1; be2 = 2'b10; d8 = 8'h3C;
    look(3'd2, 3'd2);
    chk("ln_hi_bypass_b2", qb_ln, 8'h35);
    tick();
    en = 1'b0;
    look(3'd2, 3'd2);
    chk("ln_hi_a2", qa_ln, 8'h35);
    en = 1'b1; be2 = 2'b00; d8 = 8'hFF;
    look(3'd2, 3'd2);
    chk("ln_none_bypass_a2", qa_ln, 8'h35);
    tick();
    en = 1'b0;
    look(3'd2, 3'd2);
    chk("ln_none_b2", qb_ln, 8'h35);

    // Bypass vs. no bypass
    en = 1'b1; waddr = 3'd4; d7 = 7'h11; be1 = 1'b1; be2 = 2'b00;
    tick();
    d7 = 7'h22;
    look(3'd4, 3'd5);
    chk("byp_a4_new", {1'b0, qa_byp}, 8'h22);
    chk("byp_b5_other", {1'b0, qb_byp}, 8'h07);
    chk("nob_a4_old", {1'b0, qa_nob}, 8'h11);
    look(3'd4, 3'd4);
    chk("byp_b4_new", {1'b0, qb_byp}, 8'h22);
    chk("nob_b4_old", {1'b0, qb_nob}, 8'h11);
    tick();
    en = 1'b0;
    look(3'd4, 3'd4);
    chk("nob_a4_after", {1'b0, qa_nob}, 8'h22);
    chk("nob_b4_after", {1'b0, qb_nob}, 8'h22);
    chk("byp_a4_after", {1'b0, qa_byp}, 8'h22);

    // Boundaries: zero entry and out-of-range writes
    en = 1'b1; waddr = 3'd0; d7 = 7'h7F;
    look(3'd0, 3'd0);
    chk("bnd_a0_nobypass", {1'b0, qa_bnd}, 8'h00);
    chk("byp_a0_bypass", {1'b0, qa_byp}, 8'h7F);
    tick();
    en = 1'b0;
    look(3'd0, 3'd0);
    chk("bnd_a0", {1'b0, qa_bnd}, 8'h00);
    chk("byp_b0", {1'b0, qb_byp}, 8'h7F);
    en = 1'b1; waddr = 3'd6;
    look(3'd6, 3'd6);
    chk("bnd_a6_oob_bypass", {1'b0, qa_bnd}, 8'h00);
    tick();
    waddr = 3'd7;
    tick();
    en = 1'b0;
    look(3'd6, 3'd7);
    chk("bnd_a6", {1'b0, qa_bnd}, 8'h00);
    chk("bnd_b7", {1'b0, qb_bnd}, 8'h00);
    chk("byp_a6", {1'b0, qa_byp}, 8'h7F);
    chk("byp_b7", {1'b0, qb_byp}, 8'h7F);
    look(3'd4, 3'd5);
    chk("bnd_a4_kept", {1'b0, qa_bnd}, 8'h22);
    chk("bnd_b5_kept", {1'b0, qb_bnd}, 8'h07);
    look(3'd1, 3'd3);
    chk("bnd_a1_kept", {1'b0, qa_bnd}, 8'h00);
    chk("bnd_b3_kept", {1'b0, qb_bnd}, 8'h00);
    en = 1'b1; waddr = 3'd5; d7 = 7'h5A;
    look(3'd5, 3'd5);
    chk("bnd_a5_bypass", {1'b0, qa_bnd}, 8'h5A);
    tick();
    en = 1'b0;
    look(3'd5, 3'd5);
    chk("bnd_b5", {1'b0, qb_bnd}, 8'h5A);

    // Reset in the middle of a write burst
    en = 1'b1; be1 = 1'b1; be2 = 2'b00;
    waddr = 3'd1; d7 = 7'h11;
    tick();
    waddr = 3'd2; d7 = 7'h22;
    tick();
    waddr = 3'd3; d7 = 7'h33; reset = 1'b1;
    look(3'd2, 3'd3);
    chk("mid_byp_a2", {1'b0, qa_byp}, 8'h22);
    chk("mid_byp_b3_nobypass", {1'b0, qb_byp}, 8'h00);
    tick();
    reset = 1'b0; en = 1'b0;
    for (int a = 0; a < 8; a++) begin
      look(3'(a), 3'(a));
      chk($sformatf("mid_clr_byp_a%0d", a), {1'b0, qa_byp}, 8'h00);
    end
    look(3'd3, 3'd2);
    chk("mid_clr_nob_a3", {1'b0, qa_nob}, 8'h00);
    chk("mid_clr_bnd_b2", {1'b0, qb_bnd}, 8'h00);
    chk("mid_clr_ln_b2", qb_ln, 8'h00);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_en.md
Name: reg_file_en

Overview:
- Parametrised successor to the single enabled register: a bank of DEPTH registers, each WIDTH bits wide.
- One synchronous write port with per-lane write mask.
- Two independent combinational read ports, with optional write-to-read bypass and an optional hardwired-zero entry 0.
- Used as scratch/state storage for datapath blocks in the sequential-circuit library.

Parameters:
- WIDTH, 7, data bits per entry.
- DEPTH, 8, number of entries; need not be a power of two.
- NLANES, 1, write-mask lanes; WIDTH must be divisible by NLANES; lane i = bits [(i+1)*WIDTH/NLANES-1 : i*WIDTH/NLANES].
- BYPASS, 1, 1 = a read of the address being written returns the new data in the same cycle; 0 = returns the stored (old) data.
- ZERO_REG, 0, 1 = entry 0 reads as 0 and ignores writes.
- AW (localparam), max(1, clog2(DEPTH)), address width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; one clock; all state is in the clk domain.
- en  in  1  write enable.
- waddr  in  AW  write address.
- be  in  NLANES  lane write mask; 1 = lane written.
- d  in  WIDTH  write data.
- raddr_a  in  AW  read address, port A.
- q_a  out  WIDTH  read data, port A.
- raddr_b  in  AW  read address, port B.
- q_b  out  WIDTH  read data, port B.

Behaviour:
- Reset: at a rising edge with reset=1, every entry is cleared to 0. Reset has priority over en; no write occurs that cycle.
- After a reset edge, q_a = q_b = 0 for any address, until written.
- Write: at a rising edge with reset=0, en=1, waddr<DEPTH:
  - lanes with be[i]=1 of entry[waddr] take the matching d bits;
  - lanes with be[i]=0 keep their value.
- en=1 with be=0 is a no-op.
- Write latency is 1 cycle: the value is visible at the read ports after the edge, or in the same cycle when BYPASS=1.
- Out-of-range write (waddr>=DEPTH): ignored, no entry changes.
- ZERO_REG=1: writes to address 0 are ignored; reads of address 0 return 0.
- Reads are combinational, with no clock latency. q_x = entry[raddr_x]; raddr_x>=DEPTH returns 0.
- Both ports may read the same address; they return identical data.
- Bypass (BYPASS=1): when en=1, reset=0, waddr==raddr_x, waddr<DEPTH and the address is not a ZERO_REG address, q_x is the merged word. Per lane: d where be=1, stored value where be=0.
  - Bypass is suppressed while reset=1; reads return stored contents until the edge.
- BYPASS=0: q_x shows the old contents during the write cycle and the new contents after the edge.
- Simultaneous reads on A and B plus a write, all to the same address, follow the bypass rule identically on both ports.
- Reset mid-sequence: any write presented in the reset cycle is lost. Entries written in earlier cycles are cleared at the reset edge.
- No X propagation: all entries are defined from the first reset edge; contents are undefined before the first reset.

Test Plan:
- Reset (WIDTH=7, DEPTH=8): preload entries 1..7 with 7'h55, then assert reset for 1 cycle → all reads return 7'h00; a write with en=1, waddr=3, d=7'h7F during the reset cycle is not stored.
- Basic write/read: en=1, waddr=5, d=7'b0000111, be=1 → q_a at raddr_a=5 is 7'b0000111 after the edge; en=0 with d=7'h7F in the next cycle → entry 5 unchanged.
- Lane mask (WIDTH=8, NLANES=2): entry 2=8'hA5, then write d=8'h3C, be=2'b10 → entry 2 = 8'h35; be=2'b00 → unchanged.
- Bypass (BYPASS=1): entry 4=7'h11; same cycle en=1, waddr=4, d=7'h22, raddr_a=4, raddr_b=4 → both read 7'h22 before the edge. With BYPASS=0 → both read 7'h11, then 7'h22 after the edge.
- Boundaries (DEPTH=6, ZERO_REG=1): write 7'h7F to addr 0 → read 0; write to addr 6/7 → no entry changes, reads of 6/7 return 0; addr 5 writes and reads normally.
- Reset mid-operation: write entries 1–3 on consecutive cycles, assert reset on the cycle of the write to 3 → all entries 0 afterwards, including 3.
